// File: rtl/piso_serializer_gen2_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter family.
package piso_serializer_gen2_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Counter width for a counter that spans 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/piso_serializer_gen2_if.sv
// Word-in / bit-out bus of the serializer, plus the FSM state for observation.
interface piso_serializer_gen2_if #(
  parameter int WIDTH = 27
);
  import piso_serializer_gen2_pkg::*;

  // Handshake: a word transfers on a rising clock edge where start_i=1 and
  // ready_o=1; data_i is sampled on that edge only. When ready_o=0 the start
  // is ignored and the producer must hold or retry. ready_o does not depend
  // on start_i, so it may be used to compute start_i without a loop.
  logic             start_i;
  logic [WIDTH-1:0] data_i;
  logic             ready_o;
  logic             data_o;
  logic             ena_o;
  logic             busy_o;
  logic             done_o;
  ser_state_t       state_o;

  modport master (
    output start_i, data_i,
    input  ready_o, data_o, ena_o, busy_o, done_o, state_o
  );

  modport slave (
    input  start_i, data_i,
    output ready_o, data_o, ena_o, busy_o, done_o, state_o
  );

endinterface

// File: rtl/piso_serializer_gen2_bit_timer.sv
// Bit-period divider: counts clocks within one bit and flags the last one.
module piso_serializer_gen2_bit_timer
  import piso_serializer_gen2_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic tick_o,
  output logic tick_next_o
);

  localparam int DIV_W = cnt_w(CLKS_PER_BIT);
  localparam logic [DIV_W-1:0] TERM = DIV_W'(CLKS_PER_BIT - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // tick marks the final clock of the current bit period.
  assign tick_o = run_i && (div_q == TERM);

  // Count while running, wrap explicitly at terminal count, park at 0 when stopped.
  always_comb begin
    div_d = '0;
    if (run_i && !tick_o) begin
      div_d = div_q + 1'b1;
    end
  end

  // Lets the owner register signals that must line up with the next tick.
  assign tick_next_o = (div_d == TERM);

  // Divider register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/piso_serializer_gen2.sv
// Parallel-in/serial-out transmitter with a one-word holding buffer so that
// consecutive frames leave the pins with no idle clock between them.
module piso_serializer_gen2
  import piso_serializer_gen2_pkg::*;
#(
  parameter int   WIDTH        = 27,
  parameter int   CLKS_PER_BIT = 1,
  parameter bit   LSB_FIRST    = 1'b0,
  parameter logic IDLE_LVL     = 1'b0
) (
  input logic                     clk_i,
  input logic                     rst_i,
  piso_serializer_gen2_if.slave   bus
);

  localparam int BIT_W = cnt_w(WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             data_q, data_d;
  logic             ena_q, ena_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             accept;
  logic             tick;
  logic             tick_next;
  logic             frame_end;

  piso_serializer_gen2_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .run_i       (state_q == SHIFT),
    .tick_o      (tick),
    .tick_next_o (tick_next)
  );

  assign accept    = bus.start_i && !buf_full_q;
  assign frame_end = tick && (bit_cnt_q == LAST_BIT);

  // Next-state logic: FSM, shift register, holding buffer, bit counter and
  // the next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    bit_cnt_d  = bit_cnt_q;

    case (state_q)
      IDLE: begin
        // Nothing is shifting, so the word bypasses the buffer.
        if (accept) begin
          sreg_d    = bus.data_i;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // A start on the last clock of a frame is taken straight into the
        // shift register below, so it must not also land in the buffer.
        if (accept && !frame_end) begin
          buf_d      = bus.data_i;
          buf_full_d = 1'b1;
        end
        if (frame_end) begin
          bit_cnt_d = '0;
          if (buf_full_q) begin
            sreg_d     = buf_q;
            buf_full_d = 1'b0;
          end else if (accept) begin
            sreg_d = bus.data_i;
          end else begin
            state_d = IDLE;
          end
        end else if (tick) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (LSB_FIRST) begin
            sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
          end else begin
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
          end
        end
      end
    endcase

    // Outputs are computed from the next state so the pins are pure flops.
    ena_d  = (state_d == SHIFT);
    data_d = IDLE_LVL;
    if (ena_d) begin
      data_d = LSB_FIRST ? sreg_d[0] : sreg_d[WIDTH-1];
    end
    done_d = ena_d && (bit_cnt_d == LAST_BIT) && tick_next;
    busy_d = ena_d || buf_full_d;
  end

  // State and output registers; reset drops the line to idle at once and
  // discards any buffered word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      bit_cnt_q  <= '0;
      data_q     <= IDLE_LVL;
      ena_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      ena_q      <= ena_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.ready_o = !buf_full_q;
  assign bus.data_o  = data_q;
  assign bus.ena_o   = ena_q;
  assign bus.done_o  = done_q;
  assign bus.busy_o  = busy_q;
  assign bus.state_o = state_q;

endmodule

// File: tb/tb_piso_serializer_gen2.sv
// Bench for piso_serializer_gen2: two instances (A: CPB=1, MSB first, idle 0;
// B: CPB=4, LSB first, idle 1) checked against a sample-stream model.
module tb_piso_serializer_gen2;

  localparam int W = 27;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // ---------------- DUTs ----------------
  piso_serializer_gen2_if #(.WIDTH(W)) bus_a ();
  piso_serializer_gen2_if #(.WIDTH(W)) bus_b ();

  piso_serializer_gen2 #(
    .WIDTH(W), .CLKS_PER_BIT(1), .LSB_FIRST(1'b0), .IDLE_LVL(1'b0)
  ) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_a)
  );

  piso_serializer_gen2 #(
    .WIDTH(W), .CLKS_PER_BIT(4), .LSB_FIRST(1'b1), .IDLE_LVL(1'b1)
  ) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_b)
  );

  logic         start_r [2];
  logic [W-1:0] din_r   [2];
  logic         ena_v   [2];
  logic         data_v  [2];
  logic         done_v  [2];
  logic         busy_v  [2];
  logic         ready_v [2];

  assign bus_a.start_i = start_r[0];
  assign bus_a.data_i  = din_r[0];
  assign bus_b.start_i = start_r[1];
  assign bus_b.data_i  = din_r[1];

  assign ena_v[0]   = bus_a.ena_o;
  assign data_v[0]  = bus_a.data_o;
  assign done_v[0]  = bus_a.done_o;
  assign busy_v[0]  = bus_a.busy_o;
  assign ready_v[0] = bus_a.ready_o;
  assign ena_v[1]   = bus_b.ena_o;
  assign data_v[1]  = bus_b.data_o;
  assign done_v[1]  = bus_b.done_o;
  assign busy_v[1]  = bus_b.busy_o;
  assign ready_v[1] = bus_b.ready_o;

  // ---------------- scoreboard helper ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Each accepted word becomes W*CPB line samples {last, bit} appended to a
  // queue; one sample is consumed per clock. A non-empty queue means a frame
  // bit is on the line. The holding slot is free while the queue holds no
  // more than the frame currently on the line.
  for (genvar g = 0; g < 2; g++) begin : mdl
    localparam int   CPB  = (g == 0) ? 1 : 4;
    localparam bit   LSB  = (g == 1);
    localparam logic IDLE = (g == 1) ? 1'b1 : 1'b0;

    logic [1:0] exp_q[$];
    logic e_ena   = 1'b0;
    logic e_data  = IDLE;
    logic e_done  = 1'b0;
    logic e_busy  = 1'b0;
    logic e_ready = 1'b1;
    int   ena_tot  = 0;
    int   done_tot = 0;
    int   rise_tot = 0;
    logic ena_prev = 1'b0;

    always @(posedge clk or posedge rst) begin : step
      logic rdy;
      if (rst) begin
        exp_q.delete();
      end else begin
        rdy = (exp_q.size() <= W * CPB);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (start_r[g] && rdy) begin
          for (int b = 0; b < W; b++) begin
            for (int c = 0; c < CPB; c++) begin
              exp_q.push_back({(b == W - 1) && (c == CPB - 1),
                               LSB ? din_r[g][b] : din_r[g][W-1-b]});
            end
          end
        end
      end
      e_ena   = (exp_q.size() > 0);
      e_data  = e_ena ? exp_q[0][0] : IDLE;
      e_done  = e_ena && exp_q[0][1];
      e_busy  = e_ena;
      e_ready = (exp_q.size() <= W * CPB);
    end

    always @(negedge clk) begin
      if (ena_v[g]) ena_tot++;
      if (ena_v[g] && !ena_prev) rise_tot++;
      if (done_v[g]) done_tot++;
      ena_prev = ena_v[g];
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_ena",   ena_v[0],   mdl[0].e_ena);
      check("a_data",  data_v[0],  mdl[0].e_data);
      check("a_done",  done_v[0],  mdl[0].e_done);
      check("a_busy",  busy_v[0],  mdl[0].e_busy);
      check("a_ready", ready_v[0], mdl[0].e_ready);
      check("b_ena",   ena_v[1],   mdl[1].e_ena);
      check("b_data",  data_v[1],  mdl[1].e_data);
      check("b_done",  done_v[1],  mdl[1].e_done);
      check("b_busy",  busy_v[1],  mdl[1].e_busy);
      check("b_ready", ready_v[1], mdl[1].e_ready);
    end
  end

  // ---------------- driver tasks ----------------
  // Holds start for one clock; returns 2 time units after the sampling edge.
  task automatic send(input int g, input logic [W-1:0] w);
    @(posedge clk); #2;
    start_r[g] = 1'b1;
    din_r[g]   = w;
    @(posedge clk); #2;
    start_r[g] = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  // Collects one frame starting with the clock after the accepting edge.
  task automatic capture(input int g, input bit lsb, input int cpb,
                         output logic [W-1:0] word, output int ecnt, output int dcyc);
    word = '0;
    ecnt = 0;
    dcyc = -1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk); #1;
      if (ena_v[g]) begin
        if (ecnt % cpb == 0) word = lsb ? {data_v[g], word[W-1:1]} : {word[W-2:0], data_v[g]};
        ecnt++;
      end
      if (done_v[g]) dcyc = cyc;
      if (!ena_v[g] && ecnt > 0) break;
    end
  endtask

  task automatic wait_idle(input int g, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (busy_v[g] && n < budget);
    check("idle_timeout", busy_v[g], 1'b0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [W-1:0] word;
    int ecnt, dcyc, s_ena, s_done, s_rise, n;
    start_r[0] = 1'b0;
    start_r[1] = 1'b0;
    din_r[0]   = '0;
    din_r[1]   = '0;

    #1 rst = 1'b1;
    #1;
    chk_en = 1'b1;
    check("rst_a_ready", ready_v[0], 1'b1);
    check("rst_a_ena",   ena_v[0],   1'b0);
    check("rst_a_busy",  busy_v[0],  1'b0);
    check("rst_a_done",  done_v[0],  1'b0);
    check("rst_a_data",  data_v[0],  1'b0);
    check("rst_b_ready", ready_v[1], 1'b1);
    check("rst_b_data",  data_v[1],  1'b1);
    check("rst_b_ena",   ena_v[1],   1'b0);
    release_reset();
    repeat (2) @(negedge clk);

    // Reset in idle.
    #1 rst = 1'b1;
    #1;
    check("idle_rst_ready", ready_v[0], 1'b1);
    check("idle_rst_data",  data_v[0],  1'b0);
    release_reset();

    // MSB-first frame on A.
    send(0, 27'h5A5A5A5);
    capture(0, 1'b0, 1, word, ecnt, dcyc);
    check("t2_word", word, 27'h5A5A5A5);
    check("t2_ena_clks", ecnt, 27);
    check("t2_done_clk", dcyc, 27);
    repeat (3) @(negedge clk);

    // LSB-first, four clocks per bit on B.
    send(1, 27'h0000001);
    capture(1, 1'b1, 4, word, ecnt, dcyc);
    check("t3_word", word, 27'h0000001);
    check("t3_ena_clks", ecnt, 108);
    check("t3_done_clk", dcyc, 108);
    repeat (3) @(negedge clk);

    // Reset mid-frame on B: line must go to its idle level (1) at once.
    send(1, 27'h0);
    repeat (10) @(negedge clk);
    #1;
    check("t1_b_pre_data", data_v[1], 1'b0);
    check("t1_b_pre_ena",  ena_v[1],  1'b1);
    #2 rst = 1'b1;
    #1;
    check("t1_b_data",  data_v[1],  1'b1);
    check("t1_b_ena",   ena_v[1],   1'b0);
    check("t1_b_busy",  busy_v[1],  1'b0);
    check("t1_b_ready", ready_v[1], 1'b1);
    check("t1_b_done",  done_v[1],  1'b0);
    release_reset();
    repeat (2) @(negedge clk);

    // Buffered second word, third word refused, two frames back to back.
    s_ena = mdl[0].ena_tot; s_done = mdl[0].done_tot; s_rise = mdl[0].rise_tot;
    send(0, 27'h3C0FF0A);
    send(0, 27'h1234567);
    @(negedge clk); #1;
    check("t4_ready_low", ready_v[0], 1'b0);
    check("t4_busy",      busy_v[0],  1'b1);
    send(0, 27'h7FFFFFF);
    wait_idle(0, 200);
    check("t4_ena_clks", mdl[0].ena_tot - s_ena, 54);
    check("t4_done_cnt", mdl[0].done_tot - s_done, 2);
    check("t4_rises",    mdl[0].rise_tot - s_rise, 1);
    repeat (2) @(negedge clk);

    // Start in the done clock with an empty buffer.
    s_ena = mdl[0].ena_tot; s_done = mdl[0].done_tot; s_rise = mdl[0].rise_tot;
    send(0, 27'h2AAAAAA);
    n = 0;
    while (!done_v[0] && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("t5_done_seen", done_v[0], 1'b1);
    start_r[0] = 1'b1;
    din_r[0]   = 27'h0F0F0F0;
    @(posedge clk); #2;
    start_r[0] = 1'b0;
    wait_idle(0, 200);
    check("t5_ena_clks", mdl[0].ena_tot - s_ena, 54);
    check("t5_done_cnt", mdl[0].done_tot - s_done, 2);
    check("t5_rises",    mdl[0].rise_tot - s_rise, 1);
    repeat (2) @(negedge clk);

    // Buffer path with CPB=4 on B.
    s_ena = mdl[1].ena_tot; s_done = mdl[1].done_tot; s_rise = mdl[1].rise_tot;
    send(1, 27'h5555555);
    send(1, 27'h6DB6DB6);
    wait_idle(1, 400);
    check("b2b_ena_clks", mdl[1].ena_tot - s_ena, 216);
    check("b2b_done_cnt", mdl[1].done_tot - s_done, 2);
    check("b2b_rises",    mdl[1].rise_tot - s_rise, 1);
    repeat (2) @(negedge clk);

    // Reset at bit 13 with the buffer full: buffered word must never appear.
    s_ena = mdl[0].ena_tot;
    send(0, 27'h7FFFFFF);
    send(0, 27'h5555555);
    n = 0;
    while ((mdl[0].ena_tot - s_ena) < 14 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("t6_pre_data",  data_v[0],  1'b1);
    check("t6_pre_ready", ready_v[0], 1'b0);
    #2 rst = 1'b1;
    #1;
    check("t6_data",  data_v[0],  1'b0);
    check("t6_ena",   ena_v[0],   1'b0);
    check("t6_done",  done_v[0],  1'b0);
    check("t6_busy",  busy_v[0],  1'b0);
    check("t6_ready", ready_v[0], 1'b1);
    release_reset();
    s_ena = mdl[0].ena_tot; s_done = mdl[0].done_tot;
    repeat (80) @(negedge clk);
    #1;
    check("t6_no_ena",  mdl[0].ena_tot - s_ena, 0);
    check("t6_no_done", mdl[0].done_tot - s_done, 0);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: end not reached, time %0t", $time);
    $fatal(1);
  end

endmodule
